periph_sample_fifo: RTL and testbench



---
 rtl/periph_sample_fifo.sv | 188 ++++++++++++++++++
 tb/tb_periph_sample_fifo.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_sample_fifo.sv
// Packs 2-bit I/Q front-end samples into 32-bit words and buffers them in a FIFO
// that the MCU drains through a small register window on the periph memory bus.
module periph_sample_fifo #(
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  input  logic        sample_valid,
  input  logic [1:0]  sample_i,
  input  logic [1:0]  sample_q,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [7:0] OFF_DATA   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;

  logic          r_mem_ready;
  logic [31:0]   r_mem_rdata;
  logic          r_irq;
  logic          r_enable;
  logic [7:0]    r_thr;
  logic          r_ovf;
  logic          r_udf;
  logic [LW-1:0] r_level;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_pack_word;
  logic [2:0]    r_pack_cnt;
  logic          r_push;
  logic [31:0]   r_push_word;
  logic [31:0]   r_fifo_mem [FIFO_DEPTH];

  logic          w_sel;
  logic          w_accept;
  logic          w_rd;
  logic          w_wr;
  logic [7:0]    w_off;
  logic          w_empty;
  logic          w_full;
  logic          w_data_rd;
  logic          w_pop;
  logic          w_udf_set;
  logic          w_ctrl_wr;
  logic          w_flush;
  logic          w_stat_wr;
  logic          w_push_ok;
  logic          w_ovf_set;
  logic          w_sample;
  logic [3:0]    w_nibble;
  logic [31:0]   w_pack_next;
  logic [31:0]   w_head;
  logic [31:0]   w_status;
  logic [31:0]   w_ctrl;
  logic [31:0]   w_rd_val;
  logic          w_unused_wdata;

  // Valid/ready: a request is taken when valid, decoded and not already acking;
  // ready follows for one cycle with registered rdata, and rdata is 0 otherwise.
  assign w_sel     = (mem_addr[31:8] == BASE_ADDR[31:8]);
  assign w_accept  = mem_valid && w_sel && !r_mem_ready;
  assign w_rd      = w_accept && (mem_wstrb == 4'b0000);
  assign w_wr      = w_accept && (mem_wstrb != 4'b0000);
  assign w_off     = mem_addr[7:0];

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LW'(FIFO_DEPTH));
  assign w_data_rd = w_rd && (w_off == OFF_DATA);
  assign w_pop     = w_data_rd && !w_empty;
  assign w_udf_set = w_data_rd && w_empty;
  assign w_ctrl_wr = w_wr && (w_off == OFF_CTRL);
  assign w_flush   = w_ctrl_wr && mem_wstrb[0] && mem_wdata[1];
  assign w_stat_wr = w_wr && (w_off == OFF_STATUS) && mem_wstrb[0];

  // A flush swallows a word completing in the same cycle without flagging ovf.
  assign w_push_ok = r_push && (!w_full || w_pop) && !w_flush;
  assign w_ovf_set = r_push && w_full && !w_pop && !w_flush;

  assign w_sample  = r_enable && sample_valid;
  assign w_nibble  = {sample_i, sample_q};
  assign w_head    = r_fifo_mem[r_rd_ptr];
  assign w_status  = {16'h0000, 8'(r_level), 4'h0, r_udf, r_ovf, w_full, w_empty};
  assign w_ctrl    = {16'h0000, r_thr, 7'h00, r_enable};

  assign w_unused_wdata = ^{mem_wdata[31:16], mem_wdata[7:4]};

  always_comb begin
    w_pack_next = r_pack_word;
    w_pack_next[{r_pack_cnt, 2'b00} +: 4] = w_nibble;
  end

  always_comb begin
    w_rd_val = 32'h0;
    if (w_rd) begin
      case (w_off)
        OFF_DATA:   w_rd_val = w_empty ? 32'h0 : w_head;
        OFF_STATUS: w_rd_val = w_status;
        OFF_CTRL:   w_rd_val = w_ctrl;
        default:    w_rd_val = 32'h0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_mem_ready <= 1'b0;
      r_mem_rdata <= 32'h0;
      r_irq       <= 1'b0;
      r_enable    <= 1'b0;
      r_thr       <= 8'h00;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_level     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_pack_word <= 32'h0;
      r_pack_cnt  <= 3'd0;
      r_push      <= 1'b0;
      r_push_word <= 32'h0;
    end else begin
      r_mem_ready <= w_accept;
      r_mem_rdata <= w_accept ? w_rd_val : 32'h0;

      if (w_ctrl_wr && mem_wstrb[0]) r_enable <= mem_wdata[0];
      if (w_ctrl_wr && mem_wstrb[1]) r_thr    <= mem_wdata[15:8];

      r_push      <= 1'b0;
      r_push_word <= w_pack_next;
      if (w_flush || !r_enable) begin
        r_pack_cnt  <= 3'd0;
        r_pack_word <= 32'h0;
      end else if (w_sample) begin
        if (r_pack_cnt == 3'd7) begin
          r_push      <= 1'b1;
          r_pack_cnt  <= 3'd0;
          r_pack_word <= 32'h0;
        end else begin
          r_pack_cnt  <= r_pack_cnt + 3'd1;
          r_pack_word <= w_pack_next;
        end
      end

      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push_ok, w_pop})
          2'b10:   r_level <= r_level + 1'b1;
          2'b01:   r_level <= r_level - 1'b1;
          default: r_level <= r_level;
        endcase
      end

      // A new event beats a software clear landing in the same cycle.
      if (w_flush)                       r_ovf <= 1'b0;
      else if (w_ovf_set)                r_ovf <= 1'b1;
      else if (w_stat_wr && mem_wdata[2]) r_ovf <= 1'b0;

      if (w_flush)                       r_udf <= 1'b0;
      else if (w_udf_set)                r_udf <= 1'b1;
      else if (w_stat_wr && mem_wdata[3]) r_udf <= 1'b0;

      r_irq <= r_enable && (8'(r_level) >= r_thr) && (r_thr != 8'h00);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_push_ok) r_fifo_mem[r_wr_ptr] <= r_push_word;
  end

  assign mem_ready = r_mem_ready;
  assign mem_rdata = r_mem_rdata;
  assign irq       = r_irq;

endmodule

// File: tb/tb_periph_sample_fifo.sv
// Directed bench for periph_sample_fifo: bus tasks, sample driver, expected-word
// queue for DATA reads, immediate-assertion checks and a one-line summary.
module tb_periph_sample_fifo;

  localparam logic [31:0] A_DATA   = 32'h0200_0000;
  localparam logic [31:0] A_STATUS = 32'h0200_0004;
  localparam logic [31:0] A_CTRL   = 32'h0200_0008;
  localparam logic [31:0] A_OTHER  = 32'h0200_000C;

  logic        sys_clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        sample_valid;
  logic [1:0]  sample_i;
  logic [1:0]  sample_q;
  logic        irq;

  int          checks;
  int          failures;
  logic [31:0] exp_q[$];

  periph_sample_fifo #(
    .BASE_ADDR  (32'h0200_0000),
    .FIFO_DEPTH (16)
  ) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_rdata    (mem_rdata),
    .sample_valid (sample_valid),
    .sample_i     (sample_i),
    .sample_q     (sample_q),
    .irq          (irq)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Caller must be just after a falling edge; request is presented immediately.
  task automatic bus_now(input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, output logic [31:0] rd);
    logic got;
    got       = 1'b0;
    rd        = 32'hDEAD_BEEF;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wd;
    mem_wstrb = strb;
    for (int c = 0; c < 8 && !got; c++) begin
      @(posedge sys_clk);
      #1;
      if (mem_ready) begin
        got = 1'b1;
        rd  = mem_rdata;
      end
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    check("bus_ack", {31'h0, got}, 32'h1);
  endtask

  task automatic bus(input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] strb, output logic [31:0] rd);
    @(negedge sys_clk);
    bus_now(addr, wd, strb, rd);
  endtask

  task automatic write_reg(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] strb);
    logic [31:0] dummy;
    bus(addr, wd, strb, dummy);
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    bus(addr, 32'h0, 4'h0, rd);
    check(tag, rd, exp);
  endtask

  task automatic read_data_check(input string tag);
    logic [31:0] e;
    logic [31:0] rd;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
    bus(A_DATA, 32'h0, 4'h0, rd);
    check(tag, rd, e);
  endtask

  // Feeds 8 samples; returns on the falling edge before the push edge.
  task automatic push_word(input logic [31:0] w);
    for (int n = 0; n < 8; n++) begin
      @(negedge sys_clk);
      sample_valid = 1'b1;
      sample_i     = w[4*n+2 +: 2];
      sample_q     = w[4*n +: 2];
    end
    @(negedge sys_clk);
    sample_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] w;
    logic [31:0] rd;
    logic [2:0]  nn;
    int          pulses;

    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    mem_valid    = 1'b0;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
    mem_wstrb    = 4'h0;
    sample_valid = 1'b0;
    sample_i     = 2'b00;
    sample_q     = 2'b00;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;

    // T1: reset state, then reset in the middle of a read
    check("rst_ready", {31'h0, mem_ready}, 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    read_check("rst_status", A_STATUS, 32'h0000_0001);
    read_check("rst_ctrl", A_CTRL, 32'h0000_0000);
    write_reg(A_CTRL, 32'h0000_0101, 4'b0011);
    push_word($urandom);
    repeat (2) @(posedge sys_clk);
    #1;
    check("t1_irq_before_rst", {31'h0, irq}, 32'h1);
    @(negedge sys_clk);
    mem_valid = 1'b1;
    mem_addr  = A_DATA;
    mem_wstrb = 4'h0;
    @(posedge sys_clk);
    #1;
    rst = 1'b1;
    #1;
    check("t1_ready_in_rst", {31'h0, mem_ready}, 32'h0);
    check("t1_rdata_in_rst", mem_rdata, 32'h0);
    check("t1_irq_in_rst", {31'h0, irq}, 32'h0);
    mem_valid = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;
    read_check("t1_status_after", A_STATUS, 32'h0000_0001);
    read_check("t1_ctrl_after", A_CTRL, 32'h0000_0000);
    exp_q.delete();

    // T2: packing order
    write_reg(A_CTRL, 32'h0000_0001, 4'b0001);
    for (int n = 0; n < 8; n++) begin
      @(negedge sys_clk);
      nn           = 3'(n);
      sample_valid = 1'b1;
      sample_i     = nn[2:1];
      sample_q     = {nn[0], 1'b0};
    end
    @(negedge sys_clk);
    sample_valid = 1'b0;
    read_check("t2_status_lvl1", A_STATUS, 32'h0000_0100);
    read_check("t2_data", A_DATA, 32'hECA8_6420);
    read_check("t2_status_empty", A_STATUS, 32'h0000_0001);

    // Disabling mid-word throws away the partial word
    for (int n = 0; n < 3; n++) begin
      @(negedge sys_clk);
      sample_valid = 1'b1;
      sample_i     = 2'b11;
      sample_q     = 2'b11;
    end
    @(negedge sys_clk);
    sample_valid = 1'b0;
    write_reg(A_CTRL, 32'h0000_0000, 4'b0001);
    push_word(32'hFFFF_FFFF);
    read_check("dis_status", A_STATUS, 32'h0000_0001);
    write_reg(A_CTRL, 32'h0000_0001, 4'b0001);
    w = $urandom;
    push_word(w);
    exp_q.push_back(w);
    read_data_check("dis_data_clean");
    read_check("dis_status_empty", A_STATUS, 32'h0000_0001);

    // T3: overflow with 17 words
    for (int k = 0; k < 17; k++) begin
      w = $urandom;
      push_word(w);
      if (k < 16) exp_q.push_back(w);
    end
    read_check("t3_status_full", A_STATUS, 32'h0000_1006);
    for (int k = 0; k < 16; k++) read_data_check($sformatf("t3_data%0d", k));
    read_check("t3_status_drained", A_STATUS, 32'h0000_0005);
    write_reg(A_STATUS, 32'h0000_0004, 4'b0001);
    read_check("t3_ovf_cleared", A_STATUS, 32'h0000_0001);

    // T4: underflow
    read_data_check("t4_data_empty");
    read_check("t4_status_udf", A_STATUS, 32'h0000_0009);
    write_reg(A_STATUS, 32'h0000_0008, 4'b0010);
    read_check("t4_udf_wrong_strb", A_STATUS, 32'h0000_0009);
    write_reg(A_STATUS, 32'h0000_0008, 4'b0001);
    read_check("t4_udf_cleared", A_STATUS, 32'h0000_0001);

    // T5: full FIFO, pop and push in the same cycle
    for (int k = 0; k < 16; k++) begin
      w = $urandom;
      push_word(w);
      exp_q.push_back(w);
    end
    read_check("t5_status_full", A_STATUS, 32'h0000_1002);
    w = $urandom;
    push_word(w);
    bus_now(A_DATA, 32'h0, 4'h0, rd);
    check("t5_simul_data", rd, exp_q.pop_front());
    exp_q.push_back(w);
    read_check("t5_status_no_ovf", A_STATUS, 32'h0000_1002);
    for (int k = 0; k < 16; k++) read_data_check($sformatf("t5_data%0d", k));
    read_check("t5_status_empty", A_STATUS, 32'h0000_0001);

    // T6: irq threshold and flush
    write_reg(A_CTRL, 32'h0000_0401, 4'b0011);
    for (int k = 0; k < 3; k++) begin
      w = $urandom;
      push_word(w);
      exp_q.push_back(w);
    end
    repeat (2) @(posedge sys_clk);
    #1;
    check("t6_irq_lvl3", {31'h0, irq}, 32'h0);
    w = $urandom;
    push_word(w);
    exp_q.push_back(w);
    @(posedge sys_clk);
    #1;
    check("t6_irq_lag", {31'h0, irq}, 32'h0);
    @(posedge sys_clk);
    #1;
    check("t6_irq_set", {31'h0, irq}, 32'h1);
    write_reg(A_CTRL, 32'h0000_0403, 4'b0011);
    exp_q.delete();
    check("t6_irq_at_flush", {31'h0, irq}, 32'h1);
    @(posedge sys_clk);
    #1;
    check("t6_irq_dropped", {31'h0, irq}, 32'h0);
    read_check("t6_status_flushed", A_STATUS, 32'h0000_0001);
    read_check("t6_ctrl_kept", A_CTRL, 32'h0000_0401);

    // T7: unmapped offsets, held valid, out-of-window addresses
    read_check("t7_other_rd", A_OTHER, 32'h0000_0000);
    write_reg(A_OTHER, 32'hFFFF_FFFF, 4'b1111);
    read_check("t7_ctrl_untouched", A_CTRL, 32'h0000_0401);
    @(negedge sys_clk);
    mem_valid = 1'b1;
    mem_addr  = A_STATUS;
    mem_wstrb = 4'h0;
    pulses    = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge sys_clk);
      #1;
      if (mem_ready) pulses++;
      if (c == 1) mem_valid = 1'b0;
    end
    check("t7_one_pulse", 32'(pulses), 32'd1);
    mem_addr  = 32'h0300_0000;
    mem_valid = 1'b1;
    pulses    = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge sys_clk);
      #1;
      if (mem_ready) pulses++;
    end
    mem_addr = 32'h0200_0100;
    for (int c = 0; c < 6; c++) begin
      @(posedge sys_clk);
      #1;
      if (mem_ready) pulses++;
    end
    mem_valid = 1'b0;
    check("t7_outside_no_ack", 32'(pulses), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
